ws2812b_rx: RTL

- Receive-side decoder for the single-wire WS2812B pulse-width protocol that the LED-matrix transmitter drives.
- Samples a serial line and classifies each bit by its high-pulse width.
- Assembles 24-bit GRB words MSB first, tags each word with its pixel index, and detects the latch (reset) gap that ends a frame.
- Used as a loopback checker on a spare input pin and as the bench monitor for the transmitter path.

---
 rtl/ws2812b_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: classifies high-pulse widths into bits, assembles
// 24-bit GRB words with per-frame pixel indices, and detects the latch gap.
module ws2812b_rx #(
    parameter int MIN_HIGH     = 3,
    parameter int THRESH       = 8,
    parameter int MAX_HIGH     = 20,
    parameter int LATCH_CYCLES = 600,
    parameter int IDX_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic [IDX_W:0]   frame_pixels,
    output logic             err
);

    localparam int HC_W = $clog2(MAX_HIGH + 2);
    localparam int LC_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [HC_W-1:0]  HC_ONE     = HC_W'(1);
    localparam logic [HC_W-1:0]  HC_MAX     = HC_W'(MAX_HIGH);
    localparam logic [HC_W-1:0]  HC_MIN     = HC_W'(MIN_HIGH);
    localparam logic [HC_W-1:0]  HC_THRESH  = HC_W'(THRESH);
    localparam logic [LC_W-1:0]  LC_ONE     = LC_W'(1);
    localparam logic [LC_W-1:0]  LC_LAST    = LC_W'(LATCH_CYCLES - 1);
    localparam logic [IDX_W:0]   PIX_ONE    = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   PIX_MAX    = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_meta;
    logic              r_ds;
    logic              r_ds_d;
    logic [HC_W-1:0]   r_high_cnt;
    logic [LC_W-1:0]   r_low_cnt;
    logic [4:0]        r_bit_cnt;
    logic [IDX_W:0]    r_pix_cnt;
    logic [22:0]       r_sr;
    logic [23:0]       r_pixel_data;
    logic              r_pixel_valid;
    logic [IDX_W-1:0]  r_pixel_index;
    logic              r_frame_done;
    logic [IDX_W:0]    r_frame_pixels;
    logic              r_err;

    logic w_rise;
    logic w_bit;

    assign w_rise = r_ds & ~r_ds_d;
    assign w_bit  = (r_high_cnt >= HC_THRESH);

    assign pixel_data   = r_pixel_data;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_index  = r_pixel_index;
    assign frame_done   = r_frame_done;
    assign frame_pixels = r_frame_pixels;
    assign err          = r_err;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_ds   <= 1'b0;
            r_ds_d <= 1'b0;
        end else begin
            r_meta <= din;
            r_ds   <= r_meta;
            r_ds_d <= r_ds;
        end
    end

    // Pulse-width decoder FSM with registered strobes and word/frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_SYNC;
            r_high_cnt     <= '0;
            r_low_cnt      <= '0;
            r_bit_cnt      <= 5'd0;
            r_pix_cnt      <= '0;
            r_sr           <= 23'd0;
            r_pixel_data   <= 24'd0;
            r_pixel_valid  <= 1'b0;
            r_pixel_index  <= '0;
            r_frame_done   <= 1'b0;
            r_frame_pixels <= '0;
            r_err          <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    // Counts the current low run; any high restarts alignment.
                    if (r_ds) begin
                        r_low_cnt <= '0;
                    end else if (r_low_cnt == LC_LAST) begin
                        r_low_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_low_cnt <= r_low_cnt + LC_ONE;
                    end
                end
                S_IDLE: begin
                    if (w_rise) begin
                        r_high_cnt <= HC_ONE;
                        r_state    <= S_HIGH;
                    end else begin
                        r_high_cnt <= '0;
                    end
                end
                S_HIGH: begin
                    if (r_ds) begin
                        if (r_high_cnt == HC_MAX) begin
                            r_err      <= 1'b1;
                            r_bit_cnt  <= 5'd0;
                            r_pix_cnt  <= '0;
                            r_low_cnt  <= '0;
                            r_high_cnt <= HC_MAX + HC_ONE;
                            r_state    <= S_SYNC;
                        end else begin
                            r_high_cnt <= r_high_cnt + HC_ONE;
                        end
                    end else begin
                        r_low_cnt <= LC_ONE;
                        r_state   <= S_LOW;
                        if (r_high_cnt < HC_MIN) begin
                            r_err <= 1'b1;
                        end else if (r_bit_cnt == 5'd23) begin
                            r_pixel_data  <= {r_sr, w_bit};
                            r_pixel_index <= r_pix_cnt[IDX_W-1:0];
                            r_pixel_valid <= 1'b1;
                            r_bit_cnt     <= 5'd0;
                            if (r_pix_cnt != PIX_MAX) begin
                                r_pix_cnt <= r_pix_cnt + PIX_ONE;
                            end else begin
                                r_pix_cnt <= PIX_MAX;
                            end
                        end else begin
                            r_sr      <= {r_sr[21:0], w_bit};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        r_high_cnt <= HC_ONE;
                        r_state    <= S_HIGH;
                    end else if (r_low_cnt == LC_LAST) begin
                        // Latch gap: a half-received word is an error but still closes the frame.
                        r_err <= (r_bit_cnt != 5'd0);
                        if ((r_pix_cnt != '0) || (r_bit_cnt != 5'd0)) begin
                            r_frame_done   <= 1'b1;
                            r_frame_pixels <= r_pix_cnt;
                        end else begin
                            r_frame_pixels <= r_frame_pixels;
                        end
                        r_bit_cnt <= 5'd0;
                        r_pix_cnt <= '0;
                        r_low_cnt <= LC_LAST + LC_ONE;
                        r_state   <= S_IDLE;
                    end else begin
                        r_low_cnt <= r_low_cnt + LC_ONE;
                    end
                end
                default: begin
                    r_state <= S_SYNC;
                end
            endcase
        end
    end

endmodule
